// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues one outstanding fetch at a time, buffers up
// to two {instruction, PC} pairs for the decoder and handles redirects by
// flushing the buffer and dropping any response that is still in flight.
module inst_fetch_unit #(
  parameter int WIDTH_INST_LENGTH = 32,
  parameter int WIDTH_PC_LENGTH = 32,
  parameter logic [WIDTH_PC_LENGTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         Clk,
  input  logic                         Rst,
  output logic                         IMemReq,
  output logic [WIDTH_PC_LENGTH-1:0]   IMemAddr,
  input  logic                         IMemAck,
  input  logic [WIDTH_INST_LENGTH-1:0] IMemData,
  input  logic                         PCSel,
  input  logic [WIDTH_PC_LENGTH-1:0]   ALUOut,
  output logic [WIDTH_INST_LENGTH-1:0] Inst,
  output logic [WIDTH_PC_LENGTH-1:0]   InstPC,
  output logic                         InstValid,
  input  logic                         InstReady
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam logic [WIDTH_PC_LENGTH-1:0] PC_STEP = WIDTH_PC_LENGTH'(4);

  state_e                       state_q;
  logic                         imemReq_q;
  logic [WIDTH_PC_LENGTH-1:0]   reqAddr_q;
  logic [WIDTH_PC_LENGTH-1:0]   nextPc_q;

  logic [WIDTH_INST_LENGTH-1:0] fifoInst_q [2];
  logic [WIDTH_PC_LENGTH-1:0]   fifoPc_q [2];
  logic                         rdPtr_q;
  logic                         wrPtr_q;
  logic [1:0]                   count_q;

  logic                         popEn;
  logic                         pushEn;
  logic [1:0]                   countAfterPop;
  logic                         slotFree;
  logic [WIDTH_PC_LENGTH-1:0]   pcStep;
  logic [WIDTH_PC_LENGTH-1:0]   redirectPc;
  logic                         aluLowUnused;

  // Redirect targets are forced to word alignment, so the two low bits are dropped.
  assign aluLowUnused  = ^ALUOut[1:0];
  assign redirectPc    = {ALUOut[WIDTH_PC_LENGTH-1:2], 2'b00};
  assign pcStep        = reqAddr_q + PC_STEP;

  assign popEn         = (count_q != 2'd0) && InstReady;
  assign countAfterPop = count_q - {1'b0, popEn};
  assign slotFree      = (countAfterPop != 2'd2);
  assign pushEn        = (state_q == BUSY) && IMemAck && !PCSel;

  assign IMemReq   = imemReq_q;
  assign IMemAddr  = reqAddr_q;
  assign InstValid = (count_q != 2'd0);
  assign Inst      = fifoInst_q[rdPtr_q];
  assign InstPC    = fifoPc_q[rdPtr_q];

  // Fetch sequencer: request issue, back-to-back streaming and redirect/drop handling.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      imemReq_q <= 1'b0;
      reqAddr_q <= '0;
      nextPc_q  <= RESET_PC;
    end else if (PCSel) begin
      nextPc_q <= redirectPc;
      case (state_q)
        BUSY, DROP: begin
          if (IMemAck) begin
            state_q   <= IDLE;
            imemReq_q <= 1'b0;
          end else begin
            state_q   <= DROP;
            imemReq_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          imemReq_q <= 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (slotFree) begin
            state_q   <= BUSY;
            imemReq_q <= 1'b1;
            reqAddr_q <= nextPc_q;
          end
        end
        BUSY: begin
          if (IMemAck) begin
            nextPc_q <= pcStep;
            if (countAfterPop == 2'd0) begin
              reqAddr_q <= pcStep;
            end else begin
              state_q   <= IDLE;
              imemReq_q <= 1'b0;
            end
          end
        end
        DROP: begin
          if (IMemAck) begin
            state_q   <= IDLE;
            imemReq_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          imemReq_q <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry instruction buffer; a redirect empties it after any same-cycle pop.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rdPtr_q <= 1'b0;
      wrPtr_q <= 1'b0;
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifoInst_q[i] <= '0;
        fifoPc_q[i]   <= '0;
      end
    end else begin
      if (popEn) begin
        rdPtr_q <= ~rdPtr_q;
      end
      if (pushEn) begin
        fifoInst_q[wrPtr_q] <= IMemData;
        fifoPc_q[wrPtr_q]   <= reqAddr_q;
        wrPtr_q             <= ~wrPtr_q;
      end
      count_q <= countAfterPop + {1'b0, pushEn};
      if (PCSel) begin
        rdPtr_q <= 1'b0;
        wrPtr_q <= 1'b0;
        count_q <= 2'd0;
      end
    end
  end

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 SHALL have parameter WIDTH_INST_LENGTH, default 32, instruction width delivered to the decoder.
REQ-002 SHALL have parameter WIDTH_PC_LENGTH, default 32, PC and memory address width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 SHALL use one clock and a synchronous, active-high reset:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have ports:
- IMemReq  output  1  fetch request to instruction memory.
- IMemAddr  output  WIDTH_PC_LENGTH  fetch address, word aligned.
- IMemAck  input  1  memory response valid; IMemData valid this cycle.
- IMemData  input  WIDTH_INST_LENGTH  fetched instruction word.
- PCSel  input  1  redirect (taken branch/jump) this cycle.
- ALUOut  input  WIDTH_PC_LENGTH  redirect target.
- Inst  output  WIDTH_INST_LENGTH  instruction to the decoder.
- InstPC  output  WIDTH_PC_LENGTH  PC of Inst.
- InstValid  output  1  Inst/InstPC valid.
- InstReady  input  1  decoder accepts Inst this cycle.

Function
REQ-006 SHALL hold a next-fetch register NextPC, a request-address register (drives IMemAddr) and a 2-entry FIFO of {instruction, PC}.
REQ-007 SHALL implement FSM states IDLE (no request outstanding), BUSY (request outstanding, result kept) and DROP (request outstanding, result discarded).
REQ-008 SHALL drive IMemReq = 1 in BUSY and DROP, 0 in IDLE.
REQ-009 SHALL hold IMemAddr stable while IMemReq=1 and IMemAck=0.
REQ-010 SHALL allow at most one outstanding request.
REQ-011 SHALL issue a request only when the FIFO has a free slot after this cycle's pop.
REQ-012 In IDLE with PCSel=0 and a free slot, SHALL go to BUSY and load IMemAddr <= NextPC.
REQ-013 In BUSY with IMemAck=1 and PCSel=0, SHALL push {IMemData, IMemAddr} and set NextPC <= IMemAddr+4.
REQ-014 After the REQ-013 push, if a slot remains free, SHALL stay in BUSY with IMemAddr <= IMemAddr+4 (back-to-back, 1 instruction/cycle); otherwise SHALL go to IDLE.
REQ-015 On PCSel=1 in any state, SHALL:
- flush the FIFO, with InstValid=0 the next cycle;
- set NextPC <= {ALUOut[WIDTH_PC_LENGTH-1:2], 2'b00}.
REQ-016 On PCSel=1, the next state SHALL be:
- BUSY with IMemAck=0: DROP.
- BUSY with IMemAck=1: IDLE, response discarded.
- DROP: DROP while IMemAck=0, else IDLE.
- IDLE: IDLE.
REQ-017 In DROP with IMemAck=1, SHALL discard IMemData and go to IDLE.
REQ-018 SHALL drive InstValid = FIFO non-empty, and Inst/InstPC = FIFO head.
REQ-019 SHALL pop the head on InstValid & InstReady.
REQ-020 SHALL apply push and pop in the same cycle, with push then writing the freed slot.
REQ-021 A pop in a PCSel cycle SHALL still complete; flush has priority for the resulting contents.
REQ-022 PC arithmetic SHALL wrap modulo 2^WIDTH_PC_LENGTH.
REQ-023 SHALL ignore IMemAck in IDLE.

Reset
REQ-024 While Rst=1, SHALL force:
- state IDLE, FIFO empty, NextPC=RESET_PC;
- IMemReq=0, IMemAddr=0, InstValid=0, Inst=0, InstPC=0.
REQ-025 Reset SHALL abandon any outstanding request; a late IMemAck after reset is ignored per REQ-023.
REQ-026 On the first rising edge with Rst=0, SHALL go to BUSY with IMemAddr=RESET_PC.

Verification
REQ-027 Reset then IMemAck=1 every cycle, InstReady=1 -> IMemAddr 0,4,8,...; InstValid from cycle 3 with InstPC 0,4,8, one per cycle.
REQ-028 InstReady=0, IMemAck=1 -> exactly 2 entries (PC 0,4), IMemReq drops to 0, FIFO holds; InstReady=1 resumes in order.
REQ-029 PCSel=1, ALUOut=32'h0000_0103 while BUSY with IMemAck=0 -> DROP, IMemAddr unchanged; ack discarded; next request at 32'h0000_0100.
REQ-030 PCSel=1 with ALUOut=32'h40 in the same cycle as IMemAck=1 -> no push, FIFO empty next cycle, next IMemAddr=32'h40.
REQ-031 Rst=1 mid-request with FIFO full -> IMemReq=0 and InstValid=0 next cycle; fetch restarts at RESET_PC.
REQ-032 NextPC=32'hFFFF_FFFC fetched -> next IMemAddr=32'h0000_0000.
